// File: rtl/mem_block_mover.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_mover
// Description : Memory-port master that copies a block of words or fills a
//               region with a constant, and keeps a wrapping sum of every word
//               it writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_mover #(
   parameter int S  = 32,
   parameter int L  = 256,
   parameter int AW = $clog2(L)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW:0]   len,
   input  logic [S-1:0]  fill_val,
   output logic          busy,
   output logic          done,
   output logic [S-1:0]  sum,
   output logic [AW-1:0] mem_a,
   output logic [S-1:0]  mem_wdata,
   input  logic [S-1:0]  mem_rdata,
   output logic          mem_read,
   output logic          mem_write
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_FILL  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW:0]   len_q, len_d;
   logic [S-1:0]  fill_q, fill_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [S-1:0]  buf_q, buf_d;
   logic [S-1:0]  sum_q, sum_d;
   logic          rd_en, wr_en;
   logic [AW:0]   idx_inc;

   // Widened by one bit so the last-word test works when len equals L.
   assign idx_inc = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      fill_d    = fill_q;
      idx_d     = idx_q;
      buf_d     = buf_q;
      sum_d     = sum_q;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      mem_a     = '0;
      mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d  = src;
               dst_d  = dst;
               len_d  = len;
               fill_d = fill_val;
               sum_d  = '0;
               idx_d  = '0;
               if (len == '0)
                  state_d = ST_DONE;
               else if (mode)
                  state_d = ST_FILL;
               else
                  state_d = ST_READ;
            end
         end
         ST_READ: begin
            mem_a   = src_q + idx_q;
            rd_en   = 1'b1;
            buf_d   = mem_rdata;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            mem_a     = dst_q + idx_q;
            mem_wdata = buf_q;
            wr_en     = 1'b1;
            sum_d     = sum_q + buf_q;
            idx_d     = idx_inc[AW-1:0];
            state_d   = (idx_inc == len_q) ? ST_DONE : ST_READ;
         end
         ST_FILL: begin
            mem_a     = dst_q + idx_q;
            mem_wdata = fill_q;
            wr_en     = 1'b1;
            sum_d     = sum_q + fill_q;
            idx_d     = idx_inc[AW-1:0];
            state_d   = (idx_inc == len_q) ? ST_DONE : ST_FILL;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
         buf_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         sum_q   <= sum_d;
      end
   end

   // Strobes are masked by reset so an in-flight transfer cannot commit a write.
   assign mem_read  = rd_en & ~rst;
   assign mem_write = wr_en & ~rst;
   assign busy      = (state_q == ST_READ) || (state_q == ST_WRITE) || (state_q == ST_FILL);
   assign done      = (state_q == ST_DONE);
   assign sum       = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_block_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_mover
// Description : Self-checking bench for mem_block_mover with a behavioural
//               memory, a write scoreboard and a shadow memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_mover;
   localparam int S  = 32;
   localparam int L  = 256;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mode;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW:0]   len;
   logic [S-1:0]  fill_val;
   logic          busy;
   logic          done;
   logic [S-1:0]  sum;
   logic [AW-1:0] mem_a;
   logic [S-1:0]  mem_wdata;
   logic [S-1:0]  mem_rdata;
   logic          mem_read;
   logic          mem_write;

   logic          clr;
   logic          pl_en;
   logic [AW-1:0] pl_a;
   logic [S-1:0]  pl_d;

   logic [S-1:0]  mem     [L];
   logic [S-1:0]  exp_mem [L];
   logic [AW+S-1:0] exp_q [$];

   int errors = 0;
   int checks = 0;
   int strobe_cnt = 0;

   always #5 clk = ~clk;

   mem_block_mover #(.S(S), .L(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .src       (src),
      .dst       (dst),
      .len       (len),
      .fill_val  (fill_val),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .mem_a     (mem_a),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write)
   );

   // Behavioural 256 x 32 memory: combinational read, write on the edge.
   assign mem_rdata = mem[mem_a];
   always @(posedge clk) begin
      if (clr) begin
         for (int k = 0; k < L; k++) mem[k] <= '0;
      end else if (mem_write) begin
         mem[mem_a] <= mem_wdata;
      end else if (pl_en) begin
         mem[pl_a] <= pl_d;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every write strobe is matched against the next expected (addr, data).
   always @(negedge clk) begin
      logic [AW+S-1:0] e;
      if (mem_read || mem_write) strobe_cnt++;
      if (mem_write) begin
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {56'd0, mem_a}, {56'd0, e[AW+S-1:S]});
            chk("wr_data", {32'd0, mem_wdata}, {32'd0, e[S-1:0]});
         end
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [S-1:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_a = a; pl_d = d;
      exp_mem[a] = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic mem_compare(input string tag);
      int bad = 0;
      for (int k = 0; k < L; k++) if (mem[k] !== exp_mem[k]) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic run_transfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input logic [AW:0] n, input logic [S-1:0] f,
                               input int glitch, input string name);
      logic [S-1:0]  esum = '0;
      logic [S-1:0]  v;
      logic [AW-1:0] a;
      logic [AW-1:0] sa;
      int lat, busy_cyc, strobe0, exp_lat, exp_busy;
      for (int i = 0; i < int'(n); i++) begin
         a  = d + AW'(i);
         sa = s + AW'(i);
         v  = m ? f : exp_mem[sa];
         exp_mem[a] = v;
         exp_q.push_back({a, v});
         esum += v;
      end
      exp_busy = (n == 0) ? 0 : (m ? int'(n) : 2 * int'(n));
      exp_lat  = exp_busy + 1;
      strobe0  = strobe_cnt;
      @(posedge clk); #1;
      start = 1'b1; mode = m; src = s; dst = d; len = n; fill_val = f;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      busy_cyc = 0;
      while (1) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (done || lat >= 600) break;
         @(posedge clk); #1;
         lat++;
         if (lat == glitch) begin
            start = 1'b1; src = s ^ 8'h55; dst = d ^ 8'h33; len = 9'd8; mode = ~m;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_busy_cycles"}, busy_cyc, exp_busy);
      chk({name, "_sum"}, {32'd0, sum}, {32'd0, esum});
      chk({name, "_strobes"}, strobe_cnt - strobe0, exp_busy);
      @(posedge clk); #1;
      @(negedge clk);
      chk({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
      chk({name, "_sum_hold"}, {32'd0, sum}, {32'd0, esum});
      chk({name, "_queue_empty"}, exp_q.size(), 0);
      mem_compare({name, "_mem"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; clr = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0;
      len = '0; fill_val = '0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
      for (int k = 0; k < L; k++) exp_mem[k] = '0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
      chk("reset_sum", {32'd0, sum}, 64'd0);
      chk("reset_mem_a", {56'd0, mem_a}, 64'd0);
      chk("reset_wdata", {32'd0, mem_wdata}, 64'd0);
      chk("reset_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Basic copy with a disturbing start pulse mid-transfer.
      for (int k = 0; k < 4; k++) preload(8'h10 + AW'(k), 32'(k + 1));
      run_transfer(1'b0, 8'h10, 8'h40, 9'd4, 32'h0, 3, "copy");
      chk("copy_sum_10", {32'd0, sum}, 64'd10);
      for (int k = 0; k < 4; k++) chk("copy_dst_word", {32'd0, mem[8'h40 + k]}, 64'(k + 1));

      // Fill wrapping past the top of memory.
      run_transfer(1'b1, 8'h00, 8'hFE, 9'd4, 32'hDEADBEEF, 0, "fill");
      chk("fill_sum_const", {32'd0, sum}, 64'h7AB6FBBC);
      chk("fill_wrap_word", {32'd0, mem[0]}, 64'hDEADBEEF);

      // Zero-length transfer.
      run_transfer(1'b0, 8'h00, 8'h05, 9'd0, 32'h0, 0, "len0");
      chk("len0_sum", {32'd0, sum}, 64'd0);

      // Overlapping forward copy smears the first word.
      preload(8'h00, 32'hA0A0_0001);
      preload(8'h01, 32'hB0B0_0002);
      preload(8'h02, 32'hC0C0_0003);
      preload(8'h03, 32'hD0D0_0004);
      run_transfer(1'b0, 8'h00, 8'h01, 9'd3, 32'h0, 0, "overlap");
      for (int k = 0; k < 4; k++) chk("overlap_word", {32'd0, mem[k]}, 64'hA0A0_0001);

      // Reset during the third WRITE of an 8-word copy.
      for (int k = 0; k < 8; k++) preload(8'h20 + AW'(k), 32'h100 + 32'(k));
      exp_mem[8'h60] = 32'h100; exp_q.push_back({8'h60, 32'h100});
      exp_mem[8'h61] = 32'h101; exp_q.push_back({8'h61, 32'h101});
      @(posedge clk); #1;
      start = 1'b1; mode = 1'b0; src = 8'h20; dst = 8'h60; len = 9'd8;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_in_write", {63'd0, mem_write}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_wr_gate", {62'd0, mem_read, mem_write}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
      chk("rst_sum", {32'd0, sum}, 64'd0);
      chk("rst_queue_empty", exp_q.size(), 0);
      mem_compare("rst_mem");

      // First transfer after reset behaves normally.
      run_transfer(1'b1, 8'h00, 8'h62, 9'd3, 32'h0000_1234, 0, "post_rst");
      chk("post_rst_sum_const", {32'd0, sum}, 64'h369C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
